md_seq_ctrl: RTL and testbench

//   Multi-cycle multiply/divide sequencer and HI/LO register file for the EX stage.

---
 rtl/md_seq_ctrl.sv | 134 +++++++++++++
 tb/tb_md_seq_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_seq_ctrl.sv
// Multiply/divide sequencer and HI/LO register file for the EX stage.
// A started op holds busy for a fixed latency, then commits its result to HI/LO.
module md_seq_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        mt_we,
    input  logic        mt_sel,
    input  logic        mf_sel,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mf_data
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t      state;
    logic [4:0]  count;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;
    logic        pend_commit;

    logic [63:0] prod;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] div_b;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_commit;
    logic [4:0]  res_cycles;
    logic        signed_div;

    // Signed division works on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000;
    // a zero divisor is replaced by 1 only to keep the divider defined, its result is never committed.
    always_comb begin
        signed_div = (md_op == 2'b10);
        a_mag      = (signed_div && rs_val[31]) ? -rs_val : rs_val;
        b_mag      = (signed_div && rt_val[31]) ? -rt_val : rt_val;
        div_b      = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag      = a_mag / div_b;
        r_mag      = a_mag % div_b;
        prod       = '0;
        res_hi     = '0;
        res_lo     = '0;
        res_commit = 1'b1;
        res_cycles = 5'(MULT_CYCLES);
        case (md_op)
            2'b00: begin
                prod = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
                {res_hi, res_lo} = prod;
            end
            2'b01: begin
                prod = {32'd0, rs_val} * {32'd0, rt_val};
                {res_hi, res_lo} = prod;
            end
            2'b10: begin
                res_cycles = 5'(DIV_CYCLES);
                res_lo     = (rs_val[31] ^ rt_val[31]) ? -q_mag : q_mag;
                res_hi     = rs_val[31] ? -r_mag : r_mag;
                res_commit = (rt_val != 32'd0);
            end
            default: begin
                res_cycles = 5'(DIV_CYCLES);
                res_lo     = q_mag;
                res_hi     = r_mag;
                res_commit = (rt_val != 32'd0);
            end
        endcase
    end

    // Operands are captured at launch; start and mt_we are only honoured in IDLE, start winning.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            busy        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            pend_hi     <= '0;
            pend_lo     <= '0;
            pend_commit <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= RUN;
                        count       <= res_cycles;
                        busy        <= 1'b1;
                        pend_hi     <= res_hi;
                        pend_lo     <= res_lo;
                        pend_commit <= res_commit;
                    end else if (mt_we) begin
                        if (mt_sel) begin
                            hi <= rs_val;
                        end else begin
                            lo <= rs_val;
                        end
                    end
                end
                RUN: begin
                    if (count == 5'd1) begin
                        state <= IDLE;
                        count <= '0;
                        busy  <= 1'b0;
                        if (pend_commit) begin
                            hi <= pend_hi;
                            lo <= pend_lo;
                        end
                    end else begin
                        count <= count - 5'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign mf_data = mf_sel ? hi : lo;

endmodule

// File: tb/tb_md_seq_ctrl.sv
// Randomized and directed bench for md_seq_ctrl: a stimulus process queues expected
// commits, a monitor process checks each completed op when busy falls.
module tb_md_seq_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        mt_we;
    logic        mt_sel;
    logic        mf_sel;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mf_data;

    typedef struct {
        int          n;
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        logic [31:0] new_hi;
        logic [31:0] new_lo;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;

    // reference state: architectural HI/LO and cycles left in the current op
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    int          m_left;
    logic [63:0] m_pend;

    md_seq_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .md_op(md_op),
        .rs_val(rs_val), .rt_val(rt_val), .mt_we(mt_we), .mt_sel(mt_sel),
        .mf_sel(mf_sel), .busy(busy), .hi(hi), .lo(lo), .mf_data(mf_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [63:0] old);
        int     ia;
        int     ib;
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] qv;
        logic [63:0] rv;
        ia = a;
        ib = b;
        sa = ia;
        sb = ib;
        case (op)
            2'b00: return 64'(sa * sb);
            2'b01: return {32'd0, a} * {32'd0, b};
            2'b10: begin
                if (b == 32'd0) return old;
                q  = sa / sb;
                r  = sa % sb;
                qv = q;
                rv = r;
                return {rv[31:0], qv[31:0]};
            end
            default: begin
                if (b == 32'd0) return old;
                return {a % b, a / b};
            end
        endcase
    endfunction

    // One clock cycle: drive inputs, check visible state at the falling edge, then advance the model.
    task automatic apply_stimulus(input logic st, input logic [1:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input logic we, input logic wsel,
                                  input logic rsel);
        exp_t e;
        start  = st;
        md_op  = op;
        rs_val = a;
        rt_val = b;
        mt_we  = we;
        mt_sel = wsel;
        mf_sel = rsel;
        @(negedge clk);
        check_output("busy", {31'd0, busy}, {31'd0, (m_left > 0)});
        check_output("mf_data", mf_data, rsel ? m_hi : m_lo);
        if (m_left == 0) begin
            if (st) begin
                m_left   = (op[1]) ? DIV_N : MULT_N;
                m_pend   = ref_result(op, a, b, {m_hi, m_lo});
                e.n      = m_left;
                e.old_hi = m_hi;
                e.old_lo = m_lo;
                e.new_hi = m_pend[63:32];
                e.new_lo = m_pend[31:0];
                exp_q.push_back(e);
            end else if (we) begin
                if (wsel) m_hi = a;
                else m_lo = a;
            end
        end else begin
            if (m_left == 1) begin
                m_hi = m_pend[63:32];
                m_lo = m_pend[31:0];
            end
            m_left--;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, i[0]);
    endtask

    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        apply_stimulus(1'b1, op, a, b, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: while busy, HI/LO must hold the pre-op value; when busy falls, the op is scored.
    initial begin : monitor
        int   run_len;
        logic prev_busy;
        exp_t e;
        run_len   = 0;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                run_len   = 0;
                prev_busy = 1'b0;
            end else if (busy) begin
                run_len++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL busy_unexpected: busy=1 with no op outstanding");
                end else begin
                    check_output("hold_hi", hi, exp_q[0].old_hi);
                    check_output("hold_lo", lo, exp_q[0].old_lo);
                end
                prev_busy = 1'b1;
            end else if (prev_busy) begin
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_output("busy_len", 32'(run_len), 32'(e.n));
                    check_output("commit_hi", hi, e.new_hi);
                    check_output("commit_lo", lo, e.new_lo);
                end
                run_len   = 0;
                prev_busy = 1'b0;
            end
        end
    end

    initial begin : stimulus
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        start  = 1'b0;
        md_op  = 2'b00;
        rs_val = '0;
        rt_val = '0;
        mt_we  = 1'b0;
        mt_sel = 1'b0;
        mf_sel = 1'b0;
        m_hi   = '0;
        m_lo   = '0;
        m_left = 0;
        m_pend = '0;
        rst_n  = 1'b0;
        #12;
        check_output("reset_busy", {31'd0, busy}, 32'd0);
        check_output("reset_hi", hi, 32'd0);
        check_output("reset_lo", lo, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_cycles(2);

        launch(2'b00, 32'hFFFFFFFE, 32'd3);
        idle_cycles(6);
        check_output("t1_hi", hi, 32'hFFFFFFFF);
        check_output("t1_lo", lo, 32'hFFFFFFFA);

        launch(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        idle_cycles(6);
        check_output("t2_hi", hi, 32'hFFFFFFFE);
        check_output("t2_lo", lo, 32'h00000001);

        launch(2'b10, 32'hFFFFFFF9, 32'd2);
        idle_cycles(11);
        check_output("t3_hi", hi, 32'hFFFFFFFF);
        check_output("t3_lo", lo, 32'hFFFFFFFD);

        launch(2'b10, 32'h80000000, 32'hFFFFFFFF);
        idle_cycles(11);
        check_output("t3_ovf_hi", hi, 32'h0);
        check_output("t3_ovf_lo", lo, 32'h80000000);

        apply_stimulus(1'b0, 2'b00, 32'h11, 32'd0, 1'b1, 1'b1, 1'b1);
        apply_stimulus(1'b0, 2'b00, 32'h22, 32'd0, 1'b1, 1'b0, 1'b0);
        launch(2'b11, 32'd9, 32'd0);
        idle_cycles(11);
        check_output("t4_hi", hi, 32'h11);
        check_output("t4_lo", lo, 32'h22);

        apply_stimulus(1'b0, 2'b00, 32'h1234, 32'd0, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        check_output("t5_mtlo", lo, 32'h1234);

        // mthi together with start: the op runs, the HI write is dropped
        apply_stimulus(1'b1, 2'b01, 32'd2, 32'd3, 1'b1, 1'b1, 1'b0);
        idle_cycles(2);
        apply_stimulus(1'b1, 2'b11, 32'd100, 32'd7, 1'b1, 1'b0, 1'b1);
        idle_cycles(4);
        check_output("t5_hi", hi, 32'd0);
        check_output("t5_lo", lo, 32'd6);

        launch(2'b10, 32'd1000, 32'd3);
        idle_cycles(3);
        rst_n = 1'b0;
        #2;
        check_output("t6_busy", {31'd0, busy}, 32'd0);
        check_output("t6_hi", hi, 32'd0);
        check_output("t6_lo", lo, 32'd0);
        exp_q.delete();
        m_hi   = '0;
        m_lo   = '0;
        m_left = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_cycles(12);
        launch(2'b00, 32'd7, 32'hFFFFFFFD);
        idle_cycles(6);
        check_output("t6_mult_lo", lo, 32'hFFFFFFEB);

        for (int i = 0; i < 500; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFFFFFF;
                2: a = 32'h80000000;
                3: b = 32'($urandom_range(1, 9));
                default: ;
            endcase
            apply_stimulus(($urandom_range(0, 3) == 0), op, a, b,
                           ($urandom_range(0, 4) == 0), 1'($urandom), 1'($urandom));
        end
        idle_cycles(12);
        check_output("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
